ext_unit_pipe: RTL and testbench

//   Parametrised, registered immediate-extension unit for the pipelined CPU datapath.

---
 rtl/ext_pkg.sv | 12 +
 rtl/ext_core.sv | 23 ++
 rtl/ext_unit_pipe.sv | 115 +++++++++++
 tb/tb_ext_unit_pipe.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// ext_pkg: mode codes and skid-buffer state encoding shared by the extension unit.
package ext_pkg;
  localparam logic [2:0] EXT_ZERO      = 3'd0;
  localparam logic [2:0] EXT_SIGN      = 3'd1;
  localparam logic [2:0] EXT_UPPER     = 3'd2;
  localparam logic [2:0] EXT_SIGN_SHL2 = 3'd3;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate widening; codes 4..7 are reserved and yield zero with an error flag.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  output logic [OUT_W-1:0] ext_data,
  output logic             ext_err
);
  logic [OUT_W-1:0] zext, sext;
  always_comb begin
    zext     = {{(OUT_W-IN_W){1'b0}}, in_data};
    sext     = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
    ext_err  = in_mode[2];
    ext_data = in_mode == EXT_ZERO      ? zext :
               in_mode == EXT_SIGN      ? sext :
               in_mode == EXT_UPPER     ? {in_data, {(OUT_W-IN_W){1'b0}}} :
               in_mode == EXT_SIGN_SHL2 ? {sext[OUT_W-3:0], 2'b00} : '0;
  end
endmodule

// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: registered immediate-extension stage with valid/ready on both sides.
// EXT_SKID_EN selects a 2-entry skid buffer with registered in_ready; otherwise a single register.
module ext_unit_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  logic [OUT_W-1:0] ext_data, data_q;
  logic [TAG_W-1:0] tag_q;
  logic             ext_err, err_q, valid_q, push, pop;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .in_data (in_data),
    .in_mode (in_mode),
    .ext_data(ext_data),
    .ext_err (ext_err)
  );

  assign push      = in_valid && in_ready;
  assign pop       = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_tag   = tag_q;
  assign out_err   = err_q;

`ifdef EXT_SKID_EN
  state_e           state_q;
  logic             ready_q, skid_err_q;
  logic [OUT_W-1:0] skid_data_q;
  logic [TAG_W-1:0] skid_tag_q;
  assign in_ready = ready_q;
  // main register always holds the oldest beat; skid only fills when main is stalled
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      data_q      <= '0;
      tag_q       <= '0;
      err_q       <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) begin
          data_q  <= ext_data;
          tag_q   <= in_tag;
          err_q   <= ext_err;
          valid_q <= 1'b1;
          state_q <= ST_ONE;
        end
        ST_ONE: if (push && pop) begin
          data_q <= ext_data;
          tag_q  <= in_tag;
          err_q  <= ext_err;
        end else if (push) begin
          skid_data_q <= ext_data;
          skid_tag_q  <= in_tag;
          skid_err_q  <= ext_err;
          ready_q     <= 1'b0;
          state_q     <= ST_TWO;
        end else if (pop) begin
          valid_q <= 1'b0;
          state_q <= ST_EMPTY;
        end
        ST_TWO: if (pop) begin
          data_q  <= skid_data_q;
          tag_q   <= skid_tag_q;
          err_q   <= skid_err_q;
          ready_q <= 1'b1;
          state_q <= ST_ONE;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end
`else
  assign in_ready = !valid_q || out_ready;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else if (push) begin
      data_q  <= ext_data;
      tag_q   <= in_tag;
      err_q   <= ext_err;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb_ext_unit_pipe: queue-based reference model plus directed and random traffic for ext_unit_pipe.
module tb_ext_unit_pipe;
  typedef logic [37:0] beat_t;
`ifdef EXT_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
  logic [15:0] in_data = '0;
  logic [2:0]  in_mode = '0;
  logic [4:0]  in_tag = '0, out_tag;
  logic [31:0] out_data;
  int          n_chk = 0, n_fail = 0;
  beat_t       q[$];

  ext_unit_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .CLK      (clk),
    .Reset    (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endfunction

  // expected {data, tag, err} from plain arithmetic on the mode rules
  function automatic beat_t ref_beat(logic [15:0] d, logic [2:0] m, logic [4:0] t);
    logic [31:0] s, r;
    s = d[15] ? 32'(d) + 32'hFFFF0000 : 32'(d);
    r = m == 0 ? 32'(d) : m == 1 ? s : m == 2 ? 32'(d) * 32'd65536 : m == 3 ? s * 32'd4 : 32'd0;
    return {r, t, m > 3'd3};
  endfunction

  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(SKID ? q.size() < 2 : (q.size() == 0 || out_ready)));
      if (out_valid && q.size() > 0) begin
        chk("beat", 64'({out_data, out_tag, out_err}), 64'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(ref_beat(in_data, in_mode, in_tag));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp1[4];
    beat_t       b;
    logic [4:0]  got[$];
    int          nt, cnt;
    exp1 = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    step();
    // modes with a free-running consumer
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      b = ref_beat(16'h8001, 3'(m), 5'(m));
      chk("model_mode", 64'(b[37:6]), 64'(exp1[m]));
      in_valid = 1'b1; in_data = 16'h8001; in_mode = 3'(m); in_tag = 5'(m);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("mode_valid", 64'(out_valid), 64'd1);
      chk("mode_data", 64'(out_data), 64'(exp1[m]));
      chk("mode_err", 64'(out_err), 64'd0);
      step();
    end
    in_valid = 1'b1; in_data = 16'h1234; in_mode = 3'd5; in_tag = 5'd17;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rsv_data", 64'(out_data), 64'd0);
    chk("rsv_err", 64'(out_err), 64'd1);
    chk("rsv_tag", 64'(out_tag), 64'd17);
    step();
    // backpressure: tags 1,2,3 against a stalled consumer
    out_ready = 1'b0; nt = 1;
    for (int c = 0; c < 4; c++) begin
      in_valid = nt <= 3; in_tag = 5'(nt); in_data = 16'(nt * 300); in_mode = 3'd1;
      @(negedge clk);
      chk("bp_ready", 64'(in_ready), 64'(c < (SKID ? 2 : 1)));
      if (in_valid && in_ready) nt++;
      step();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      in_valid = nt <= 3; in_tag = 5'(nt); in_data = 16'(nt * 300);
      @(negedge clk);
      if (out_valid && out_ready) got.push_back(out_tag);
      if (in_valid && in_ready) nt++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++) chk("bp_order", 64'(i < got.size() ? got[i] : 5'd31), 64'(i + 1));
    // streaming at full rate
    cnt = 0;
    for (int c = 0; c < 101; c++) begin
      in_valid = c < 100; in_data = 16'($urandom); in_mode = 3'($urandom % 8); in_tag = 5'($urandom);
      @(negedge clk);
      if (out_valid && out_ready) cnt++;
      step();
    end
    chk("stream_count", 64'(cnt), 64'd100);
    // reset with the buffer filled
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd0;
    for (int c = 0; c < 3; c++) begin
      in_tag = 5'(20 + c); in_data = 16'($urandom);
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b1; in_data = 16'h0055; in_mode = 3'd0; in_tag = 5'd9; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_tag", 64'(out_tag), 64'd9);
    chk("post_rst_data", 64'(out_data), 64'h55);
    step();
    // random handshake toggling with occasional reset
    for (int c = 0; c < 10000; c++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      in_data = 16'($urandom); in_mode = 3'($urandom); in_tag = 5'($urandom);
      rst = ($urandom % 400) == 0;
      step();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_model", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
